// File: rtl/safe_pkg.sv
// Shared types and constants for the digital-safe controller.
package safe_pkg;

    // Controller state encoding as seen on the display; 3'b110 is unused.
    typedef enum logic [2:0] {
        S_OFF    = 3'b000,
        S_ON     = 3'b001,
        S_WRONG1 = 3'b010,
        S_WRONG2 = 3'b011,
        S_OPEN   = 3'b100,
        S_RESET  = 3'b101,
        S_LOCK   = 3'b111
    } state_e;

    // Key codes: digits 0..9 map to their own value.
    localparam logic [3:0] KEY_DIGIT_MAX = 4'h9;
    localparam logic [3:0] KEY_STAR      = 4'hA;
    localparam logic [3:0] KEY_HASH      = 4'hB;

    // Password / entry buffer geometry.
    localparam int PW_MAX_LEN = 6;
    localparam int PW_BITS    = 4 * PW_MAX_LEN;

    // Thermometer code of a digit count, filled from the MSB downward.
    function automatic logic [PW_MAX_LEN-1:0] thermo(input logic [2:0] n);
        logic [PW_MAX_LEN-1:0] t;
        t = '0;
        for (int i = 0; i < PW_MAX_LEN; i++) begin
            t[PW_MAX_LEN-1-i] = (i < int'(n));
        end
        return t;
    endfunction

    // Mask covering the low n nibbles of a packed password.
    function automatic logic [PW_BITS-1:0] len_mask(input logic [2:0] n);
        logic [PW_BITS-1:0] m;
        m = '0;
        for (int i = 0; i < PW_MAX_LEN; i++) begin
            m[i*4 +: 4] = (i < int'(n)) ? 4'hF : 4'h0;
        end
        return m;
    endfunction

endpackage

// File: rtl/keypad_decoder.sv
// 4x3 keypad front end: synchronizes the raw lines, rejects ambiguous
// presses, debounces, and emits exactly one key event per press. Also
// produces a one-cycle pulse on the synchronized rising edge of the
// password-change button.
module keypad_decoder
    import safe_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       init_n,
    input  logic [3:0] row_i,
    input  logic [2:0] col_i,
    input  logic       reset_password_i,
    output logic       key_valid_o,
    output logic [3:0] key_code_o,
    output logic       pw_rise_o
);

    localparam int             CW        = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  DB_TARGET = CW'(DEBOUNCE_CYCLES);

    // Bit layout of the synchronizer: {reset_password, col[2:0], row[3:0]}
    logic [7:0]    sync1_q, sync2_q;
    logic          rp_prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    last_q, last_d;
    logic          fired_q, fired_d;
    logic          fire;
    logic          key_valid_q;
    logic [3:0]    key_code_q;
    logic          pw_rise_q;

    logic [3:0] row_s;
    logic [2:0] col_s;
    logic       rp_s;
    logic       key_ok;
    logic [1:0] row_idx, col_idx;
    logic [3:0] code;

    assign row_s  = sync2_q[3:0];
    assign col_s  = sync2_q[6:4];
    assign rp_s   = sync2_q[7];
    assign key_ok = $onehot(row_s) && $onehot(col_s);

    // Position of the single active row and column.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        row_idx = 2'd0;
        col_idx = 2'd0;
        case (row_s)
            4'b0010: row_idx = 2'd1;
            4'b0100: row_idx = 2'd2;
            4'b1000: row_idx = 2'd3;
            default: row_idx = 2'd0;
        endcase
        case (col_s)
            3'b010:  col_idx = 2'd1;
            3'b100:  col_idx = 2'd2;
            default: col_idx = 2'd0;
        endcase
    end

    // Map the (row, col) position onto a key code.
    always_comb begin
        code = 4'h0;
        if (row_idx == 2'd3) begin
            case (col_idx)
                2'd0:    code = KEY_STAR;
                2'd1:    code = 4'h0;
                default: code = KEY_HASH;
            endcase
        end else begin
            code = {2'b00, row_idx} * 4'd3 + {2'b00, col_idx} + 4'd1;
        end
    end

    // Debounce: count consecutive cycles of the same valid key, fire once on
    // reaching the target, and re-arm only after the keypad reads idle.
    always_comb begin
        cnt_d   = cnt_q;
        last_d  = last_q;
        fired_d = fired_q;
        fire    = 1'b0;
        if (!key_ok) begin
            cnt_d   = '0;
            fired_d = 1'b0;
        end else if (cnt_q == '0 || code != last_q) begin
            cnt_d  = {{(CW-1){1'b0}}, 1'b1};
            last_d = code;
        end else if (cnt_q != DB_TARGET) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (key_ok && cnt_d == DB_TARGET && !fired_q) begin
            fire    = 1'b1;
            fired_d = 1'b1;
        end
    end

    // Synchronizers, debounce state and registered event outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!init_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            rp_prev_q   <= 1'b0;
            cnt_q       <= '0;
            last_q      <= 4'h0;
            fired_q     <= 1'b0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
            pw_rise_q   <= 1'b0;
        end else begin
            sync1_q     <= {reset_password_i, col_i, row_i};
            sync2_q     <= sync1_q;
            rp_prev_q   <= rp_s;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            fired_q     <= fired_d;
            key_valid_q <= fire;
            key_code_q  <= code;
            pw_rise_q   <= rp_s & ~rp_prev_q;
        end
    end

    assign key_valid_o = key_valid_q;
    assign key_code_o  = key_code_q;
    assign pw_rise_o   = pw_rise_q;

endmodule

// File: rtl/safe_fsm.sv
// Digital-safe controller: PIN entry buffer, stored password, attempt
// tracking, open / password-change / lockout states.
module safe_fsm
    import safe_pkg::*;
#(
    parameter int          DEBOUNCE_CYCLES = 100000,
    parameter logic [23:0] DEFAULT_PW      = 24'h001234,
    parameter int          DEFAULT_LEN     = 4
) (
    input  logic       clk,
    input  logic       initialize,
    input  logic       row1,
    input  logic       row2,
    input  logic       row3,
    input  logic       row4,
    input  logic       col1,
    input  logic       col2,
    input  logic       col3,
    input  logic       reset_password,
    output logic [5:0] password_led,
    output logic [2:0] state
);

    localparam logic [2:0]         DEF_LEN = 3'(DEFAULT_LEN);
    // Unused upper nibbles are forced to zero so they match a shifted-in entry.
    localparam logic [PW_BITS-1:0] DEF_PW  = DEFAULT_PW & len_mask(DEF_LEN);

    logic       key_valid;
    logic [3:0] key_code;
    logic       pw_rise;

    keypad_decoder #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_keypad (
        .clk              (clk),
        .init_n           (initialize),
        .row_i            ({row4, row3, row2, row1}),
        .col_i            ({col3, col2, col1}),
        .reset_password_i (reset_password),
        .key_valid_o      (key_valid),
        .key_code_o       (key_code),
        .pw_rise_o        (pw_rise)
    );

    state_e             state_q, state_d;
    logic [PW_BITS-1:0] buf_q, buf_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [PW_BITS-1:0] pw_q, pw_d;
    logic [2:0]         len_q, len_d;
    logic [5:0]         led_q, led_d;

    logic               key_digit, key_star, key_hash;
    logic               can_append;
    logic [PW_BITS-1:0] buf_append;
    logic               entry_match;
    state_e             wrong_next;

    assign key_digit   = key_valid && (key_code <= KEY_DIGIT_MAX);
    assign key_star    = key_valid && (key_code == KEY_STAR);
    assign key_hash    = key_valid && (key_code == KEY_HASH);
    // Digits shift in at the bottom, so the first digit ends up highest.
    assign can_append  = (cnt_q < 3'(PW_MAX_LEN));
    assign buf_append  = {buf_q[PW_BITS-5:0], key_code};
    assign entry_match = (cnt_q == len_q) && (buf_q == pw_q);

    // Attempt ladder after a failed comparison.
    always_comb begin
        wrong_next = S_LOCK;
        case (state_q)
            S_ON:     wrong_next = S_WRONG1;
            S_WRONG1: wrong_next = S_WRONG2;
            default:  wrong_next = S_LOCK;
        endcase
    end

    // Next-state, entry-buffer and password-update logic.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        pw_d    = pw_q;
        len_d   = len_q;

        case (state_q)
            S_OFF: begin
                if (key_hash) state_d = S_ON;
            end
            S_ON, S_WRONG1, S_WRONG2: begin
                if (key_digit) begin
                    if (can_append) begin
                        buf_d = buf_append;
                        cnt_d = cnt_q + 3'd1;
                    end
                end else if (key_star) begin
                    buf_d = '0;
                    cnt_d = 3'd0;
                end else if (key_hash && cnt_q != 3'd0) begin
                    state_d = entry_match ? S_OPEN : wrong_next;
                end
            end
            S_OPEN: begin
                // The password-change button wins over a simultaneous key.
                if (pw_rise) begin
                    state_d = S_RESET;
                end else if (key_hash || key_star) begin
                    state_d = S_ON;
                end
            end
            S_RESET: begin
                if (key_digit) begin
                    if (can_append) begin
                        buf_d = buf_append;
                        cnt_d = cnt_q + 3'd1;
                    end
                end else if (key_star) begin
                    buf_d = '0;
                    cnt_d = 3'd0;
                end else if (key_hash && cnt_q != 3'd0) begin
                    pw_d    = buf_q;
                    len_d   = cnt_q;
                    state_d = S_ON;
                end
            end
            S_LOCK: begin
                state_d = S_LOCK;
            end
            default: begin
                state_d = S_OFF;
            end
        endcase

        // Any state change starts a fresh entry.
        if (state_d != state_q) begin
            buf_d = '0;
            cnt_d = 3'd0;
        end

        led_d = thermo(cnt_d);
    end

    // State, entry buffer, stored password and LED registers.
    always_ff @(posedge clk) begin
        if (!initialize) begin
            state_q <= S_OFF;
            buf_q   <= '0;
            cnt_q   <= 3'd0;
            pw_q    <= DEF_PW;
            len_q   <= DEF_LEN;
            led_q   <= 6'b000000;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            pw_q    <= pw_d;
            len_q   <= len_d;
            led_q   <= led_d;
        end
    end

    assign state        = state_q;
    assign password_led = led_q;

endmodule

// File: tb/tb_safe_fsm.sv
// Self-checking bench for safe_fsm: directed test-plan steps followed by
// randomized key traffic, compared against a behavioural safe model.
module tb_safe_fsm;

    logic       clk = 1'b0;
    logic       initialize;
    logic [3:0] rows;
    logic [2:0] cols;
    logic       reset_password;
    logic [5:0] password_led;
    logic [2:0] state;

    always #5 clk = ~clk;

    safe_fsm #(
        .DEBOUNCE_CYCLES(4),
        .DEFAULT_PW     (24'h001234),
        .DEFAULT_LEN    (4)
    ) dut (
        .clk            (clk),
        .initialize     (initialize),
        .row1           (rows[0]),
        .row2           (rows[1]),
        .row3           (rows[2]),
        .row4           (rows[3]),
        .col1           (cols[0]),
        .col2           (cols[1]),
        .col3           (cols[2]),
        .reset_password (reset_password),
        .password_led   (password_led),
        .state          (state)
    );

    int errors = 0;
    int checks = 0;

    // Behavioural model: mode, tries remaining, entry and password as digit lists.
    typedef enum {M_OFF, M_ARMED, M_OPEN, M_NEWPW, M_LOCK} mode_e;
    mode_e mode;
    int    tries;
    int    entry[$];
    int    pw[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] exp_state();
        case (mode)
            M_OFF:   return 3'd0;
            M_ARMED: return 3'(4 - tries);
            M_OPEN:  return 3'd4;
            M_NEWPW: return 3'd5;
            default: return 3'd7;
        endcase
    endfunction

    function automatic logic [5:0] exp_led();
        int n;
        n = entry.size();
        return 6'((63 << (6 - n)) & 63);
    endfunction

    function automatic void go(input mode_e m);
        mode = m;
        entry.delete();
    endfunction

    function automatic bit entry_is_pw();
        if (entry.size() != pw.size()) return 1'b0;
        foreach (entry[i]) if (entry[i] != pw[i]) return 1'b0;
        return 1'b1;
    endfunction

    // Keys: 0..9 digits, 10 = '*', 11 = '#'.
    function automatic void model_key(input int k);
        case (mode)
            M_OFF: if (k == 11) begin tries = 3; go(M_ARMED); end
            M_ARMED: begin
                if (k < 10) begin
                    if (entry.size() < 6) entry.push_back(k);
                end else if (k == 10) begin
                    entry.delete();
                end else if (entry.size() > 0) begin
                    if (entry_is_pw()) go(M_OPEN);
                    else begin
                        tries--;
                        if (tries == 0) go(M_LOCK);
                        else go(M_ARMED);
                    end
                end
            end
            M_OPEN: if (k >= 10) begin tries = 3; go(M_ARMED); end
            M_NEWPW: begin
                if (k < 10) begin
                    if (entry.size() < 6) entry.push_back(k);
                end else if (k == 10) begin
                    entry.delete();
                end else if (entry.size() > 0) begin
                    pw = entry;
                    tries = 3;
                    go(M_ARMED);
                end
            end
            default: ;
        endcase
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, " state"}, 32'(state), 32'(exp_state()));
        check({tag, " led"}, 32'(password_led), 32'(exp_led()));
    endtask

    // Hold one key for 'hold' cycles, release, then let the pipeline settle.
    task automatic drive_key(input int k, input int hold);
        int r, c;
        if (k >= 1 && k <= 9) begin r = (k - 1) / 3; c = (k - 1) % 3; end
        else if (k == 0)      begin r = 3; c = 1; end
        else if (k == 10)     begin r = 3; c = 0; end
        else                  begin r = 3; c = 2; end
        rows = 4'(1 << r);
        cols = 3'(1 << c);
        repeat (hold) @(negedge clk);
        rows = '0;
        cols = '0;
        repeat (6) @(negedge clk);
    endtask

    task automatic press(input int k, input string tag);
        drive_key(k, 8);
        model_key(k);
        check_outputs($sformatf("%s key%0d", tag, k));
    endtask

    function automatic int char_key(input byte ch);
        if (ch == "*") return 10;
        if (ch == "#") return 11;
        return int'(ch) - int'("0");
    endfunction

    task automatic type_seq(input string s);
        for (int i = 0; i < s.len(); i++) press(char_key(s[i]), s);
    endtask

    task automatic init_pulse();
        initialize = 1'b0;
        repeat (2) @(negedge clk);
        initialize = 1'b1;
        @(negedge clk);
        mode  = M_OFF;
        tries = 3;
        entry.delete();
        pw = '{1, 2, 3, 4};
        check_outputs("init");
    endtask

    task automatic rp_pulse();
        reset_password = 1'b1;
        repeat (3) @(negedge clk);
        reset_password = 1'b0;
        repeat (5) @(negedge clk);
        if (mode == M_OPEN) go(M_NEWPW);
        check_outputs("reset_password");
    endtask

    initial begin
        initialize     = 1'b0;
        rows           = '0;
        cols           = '0;
        reset_password = 1'b0;
        @(negedge clk);

        // Power-on and first arm.
        init_pulse();
        type_seq("#");

        // Correct PIN, then close again with '*'.
        type_seq("1234#");
        type_seq("*");

        // Three wrong attempts lock; the correct PIN is then ignored.
        type_seq("9999#9999#9999#");
        type_seq("1234#");
        rp_pulse();
        init_pulse();

        // Password change to "50", old PIN now fails, new one opens.
        type_seq("#1234#");
        rp_pulse();
        type_seq("50#");
        type_seq("1234#");
        type_seq("50#");

        // Six-digit password; a seventh digit is ignored.
        rp_pulse();
        type_seq("123456#");
        type_seq("1234567#");
        type_seq("*");

        // Clear mid-entry, empty '#', and reset_password outside OPEN.
        type_seq("12*");
        type_seq("#");
        rp_pulse();

        // Two columns at once: no key.
        rows = 4'b0001;
        cols = 3'b011;
        repeat (10) @(negedge clk);
        rows = '0;
        cols = '0;
        repeat (6) @(negedge clk);
        check_outputs("two cols");

        // Released before the debounce target: no key.
        drive_key(5, 2);
        check_outputs("short press");

        // Long hold counts exactly one digit.
        drive_key(5, 20);
        model_key(5);
        check_outputs("long hold");
        type_seq("*");

        // Randomized traffic against the model.
        for (int it = 0; it < 150; it++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (mode == M_LOCK && r < 40) begin
                init_pulse();
            end else if (r < 8) begin
                rp_pulse();
            end else if (mode == M_ARMED && r < 30) begin
                int saved[$];
                saved = pw;
                foreach (saved[i]) press(saved[i], "rnd pin");
                press(11, "rnd pin");
            end else begin
                press(int'($urandom_range(0, 11)), "rnd");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
